// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: drives the ROM address/enable and registers the
// PC/instruction pair into the IF/ID boundary, with stall, redirect and flush.
module if_fetch_unit #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_if_i,
  input  logic              stall_id_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] new_pc_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic [INST_W-1:0] inst_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              ce_o,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o,
  output logic              id_adel_o,
  output logic [31:0]       fetch_cnt_o
);

  typedef enum logic [1:0] {BOOT, RUN, BR_PEND} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
    logic              adel;
  } ifid_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc_n, pend_q, pend_n;
  logic              ce_n;
  ifid_t             id_q, id_n;
  logic [31:0]       cnt_n;

  always_comb begin
    state_n = state;
    pc_n    = pc_o;
    ce_n    = ce_o;
    pend_n  = pend_q;
    id_n    = id_q;
    cnt_n   = fetch_cnt_o;
    case (state)
      BOOT: begin
        ce_n    = 1'b1;
        pc_n    = RESET_PC;
        state_n = RUN;
        id_n    = '0;
      end
      default: begin
        if (flush_i) begin
          pc_n    = new_pc_i;
          pend_n  = '0;
          state_n = RUN;
          id_n    = '0;
        end else if (stall_if_i) begin
          // PC frozen; a branch arriving now is parked until the stall lifts
          if (branch_flag_i) begin
            pend_n  = branch_target_i;
            state_n = BR_PEND;
          end
          if (!stall_id_i) id_n = '0;
        end else begin
          if (branch_flag_i) begin
            pc_n    = branch_target_i;
            state_n = RUN;
          end else if (state == BR_PEND) begin
            pc_n    = pend_q;
            state_n = RUN;
          end else begin
            pc_n = pc_o + ADDR_W'(4);
          end
          id_n.pc = pc_o;
          if (pc_o[1:0] == 2'b00) begin
            id_n.inst = inst_i;
            id_n.adel = 1'b0;
          end else begin
            id_n.inst = '0;
            id_n.adel = 1'b1;
          end
          if (ce_o) cnt_n = fetch_cnt_o + 32'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      ce_o        <= 1'b0;
      pc_o        <= '0;
      pend_q      <= '0;
      id_q        <= '0;
      fetch_cnt_o <= '0;
    end else begin
      state       <= state_n;
      ce_o        <= ce_n;
      pc_o        <= pc_n;
      pend_q      <= pend_n;
      id_q        <= id_n;
      fetch_cnt_o <= cnt_n;
    end
  end

  assign id_pc_o   = id_q.pc;
  assign id_inst_o = id_q.inst;
  assign id_adel_o = id_q.adel;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: a behavioural model predicts every
// post-edge output set, which is queued and compared after the edge.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, stall_if_i, stall_id_i, flush_i, branch_flag_i;
  logic [31:0] new_pc_i, branch_target_i, inst_i;
  logic [31:0] pc_o, id_pc_o, id_inst_o, fetch_cnt_o;
  logic        ce_o, id_adel_o;

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk(clk), .rst(rst), .stall_if_i(stall_if_i), .stall_id_i(stall_id_i),
    .flush_i(flush_i), .new_pc_i(new_pc_i), .branch_flag_i(branch_flag_i),
    .branch_target_i(branch_target_i), .inst_i(inst_i), .pc_o(pc_o), .ce_o(ce_o),
    .id_pc_o(id_pc_o), .id_inst_o(id_inst_o), .id_adel_o(id_adel_o),
    .fetch_cnt_o(fetch_cnt_o)
  );

  // ROM: word k holds k; disabled ROM reads zero
  assign inst_i = ce_o ? (pc_o >> 2) : 32'h0;

  typedef struct {
    logic [31:0] pc, idpc, idinst, cnt;
    logic        ce, adel;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // model state: 0=boot, 1=run, 2=branch pending
  int          m_st;
  logic        m_ce, m_adel;
  logic [31:0] m_pc, m_pend, m_idpc, m_idinst, m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic sif, input logic sid, input logic fl,
                      input logic [31:0] npc, input logic br, input logic [31:0] bt);
    exp_t e;
    rst = r; stall_if_i = sif; stall_id_i = sid; flush_i = fl;
    new_pc_i = npc; branch_flag_i = br; branch_target_i = bt;
    if (r) begin
      m_st = 0; m_ce = 0; m_pc = 0; m_pend = 0; m_idpc = 0; m_idinst = 0; m_adel = 0; m_cnt = 0;
    end else if (m_st == 0) begin
      m_st = 1; m_ce = 1; m_pc = 32'h0; m_idpc = 0; m_idinst = 0; m_adel = 0;
    end else if (fl) begin
      m_st = 1; m_pc = npc; m_pend = 0; m_idpc = 0; m_idinst = 0; m_adel = 0;
    end else if (sif) begin
      if (br) begin m_st = 2; m_pend = bt; end
      if (!sid) begin m_idpc = 0; m_idinst = 0; m_adel = 0; end
    end else begin
      m_idpc   = m_pc;
      m_adel   = (m_pc[1:0] != 2'b00);
      m_idinst = m_adel ? 32'h0 : (m_pc >> 2);
      m_cnt    = m_cnt + 1;
      if (br) m_pc = bt;
      else if (m_st == 2) m_pc = m_pend;
      else m_pc = m_pc + 4;
      m_st = 1;
    end
    e.pc = m_pc; e.ce = m_ce; e.idpc = m_idpc; e.idinst = m_idinst; e.adel = m_adel; e.cnt = m_cnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL sb_empty: got 0 entries want 1");
    end else begin
      e = exp_q.pop_front();
      chk("pc_o", pc_o, e.pc);
      chk("ce_o", {31'h0, ce_o}, {31'h0, e.ce});
      chk("id_pc_o", id_pc_o, e.idpc);
      chk("id_inst_o", id_inst_o, e.idinst);
      chk("id_adel_o", {31'h0, id_adel_o}, {31'h0, e.adel});
      chk("fetch_cnt_o", fetch_cnt_o, e.cnt);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; stall_if_i = 0; stall_id_i = 0; flush_i = 0;
    new_pc_i = 0; branch_flag_i = 0; branch_target_i = 0;
    @(negedge clk);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("rst_ce", {31'h0, ce_o}, 32'h0);

    // boot then sequential fetch
    idle(1);
    chk("boot_pc", pc_o, 32'h0);
    chk("boot_ce", {31'h0, ce_o}, 32'h1);
    idle(3);
    chk("seq_pc", pc_o, 32'hC);
    chk("seq_inst", id_inst_o, 32'h2);
    chk("seq_cnt", fetch_cnt_o, 32'd3);
    idle(1);

    // full stall at 0x10
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 0, 0);
    chk("stall_pc", pc_o, 32'h10);
    chk("stall_cnt", fetch_cnt_o, 32'd4);
    idle(1);
    chk("unstall_pc", pc_o, 32'h14);

    // IF stalled, ID running: bubble
    step(0, 1, 0, 0, 0, 0, 0);
    chk("bubble_inst", id_inst_o, 32'h0);
    chk("bubble_pc", pc_o, 32'h14);

    // branch parked during stall
    step(0, 1, 1, 0, 0, 1, 32'h40);
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("pend_pc", pc_o, 32'h40);
    idle(1);
    chk("pend_next", pc_o, 32'h44);

    // flush beats stalled branch and discards it
    step(0, 1, 1, 1, 32'h180, 1, 32'h40);
    chk("flush_pc", pc_o, 32'h180);
    idle(1);
    chk("flush_nopend", pc_o, 32'h184);

    // misaligned branch target
    step(0, 0, 0, 0, 0, 1, 32'h42);
    idle(1);
    chk("adel_pc", id_pc_o, 32'h42);
    chk("adel_flag", {31'h0, id_adel_o}, 32'h1);
    idle(1);

    // wrap at the top of the address space
    step(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    idle(1);
    chk("wrap_pc", pc_o, 32'h0);

    // later stalled branch overwrites the parked one
    step(0, 1, 1, 0, 0, 1, 32'h100);
    step(0, 1, 0, 0, 0, 1, 32'h200);
    idle(1);
    chk("overwrite_pc", pc_o, 32'h200);

    // live branch beats parked one
    step(0, 1, 1, 0, 0, 1, 32'h300);
    step(0, 0, 0, 0, 0, 1, 32'h500);
    chk("live_pc", pc_o, 32'h500);
    idle(1);

    // reset while a branch is parked
    step(0, 1, 1, 0, 0, 1, 32'h600);
    step(1, 1, 1, 0, 0, 0, 0);
    idle(3);
    chk("rst_pend_pc", pc_o, 32'h8);

    // randomised traffic checked by the scoreboard
    for (int i = 0; i < 300; i++) begin
      logic [31:0] t, np;
      t  = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      np = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      if ($urandom_range(0, 15) == 0) t[1:0] = 2'($urandom_range(1, 3));
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 1) == 0), ($urandom_range(0, 15) == 0),
           np, ($urandom_range(0, 5) == 0), t);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
